sorted_unpacker: RTL
====================

SORTED_UNPACKER -- requirements
Module: sorted_unpacker

Interface
REQ-001 SHALL have parameter LANES, default 8, meaning byte lanes per packed word.
REQ-002 SHALL have parameter LANE_W, default 8, meaning bits per lane.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL have port in_data, input, LANES*LANE_W (64) bits: packed sorted word; lane k = in_data[8k+7:8k].
REQ-006 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-008 SHALL have port out_byte, output, LANE_W bits: current lane value.
REQ-009 SHALL have port out_index, output, 3 bits: lane number of out_byte.
REQ-010 SHALL have port out_valid, output, 1 bit: out_byte/out_index/out_last valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the byte.
REQ-012 SHALL have port out_last, output, 1 bit: high with lane LANES-1.
REQ-013 SHALL have port order_err, output, 1 bit: one-cycle pulse, captured word not non-increasing.
REQ-014 SHALL have port err_count, output, 8 bits: saturating count of order_err pulses.

Function
REQ-015 SHALL treat a word as transferred on any cycle where in_valid and in_ready are both high.
REQ-016 SHALL treat a byte as transferred on any cycle where out_valid and out_ready are both high.
REQ-017 SHALL implement a two-state FSM: IDLE (no word held) and SEND (word held, emitting lanes).
REQ-018 SHALL drive in_ready high in IDLE; in SEND only when out_last and out_ready are both high (back-to-back).
REQ-019 SHALL transition IDLE->SEND on word transfer, capturing in_data into a 64-bit holding register and setting index to 0.
REQ-020 SHALL present lane 0 with out_valid high on the cycle after the word transfer (latency 1).
REQ-021 SHALL emit lanes in order 0,1,...,LANES-1, one per byte transfer, so the largest value leaves first.
REQ-022 SHALL hold out_byte, out_index and out_last stable while out_valid is high and out_ready is low.
REQ-023 SHALL, on transfer of lane LANES-1: go to IDLE if in_valid is low; else capture the new word, stay in SEND and present its lane 0 next cycle with no bubble.
REQ-024 SHALL check at capture that lane k >= lane k+1 (unsigned) for all k in 0..LANES-2.
REQ-025 SHALL pulse order_err for exactly one cycle, the cycle after capture, if any pair violates REQ-024; equal lanes are not violations.
REQ-026 SHALL increment err_count on each order_err pulse, saturating at 255.
REQ-027 SHALL still emit all lanes unchanged for a word that fails the order check.
REQ-028 SHALL keep out_valid low in IDLE; out_byte/out_index are don't-care there but SHALL be driven to 0.

Reset
REQ-029 SHALL, on rst high, force state IDLE, index 0, holding register 0, out_valid 0, out_last 0, out_byte 0, out_index 0, order_err 0, err_count 0; in_ready reads 1 on the first cycle after release.
REQ-030 SHALL discard any partially emitted word on reset mid-SEND; no further lanes of it appear.
REQ-031 SHALL give rst priority over simultaneous in_valid/in_ready transfer; the word is dropped.

Structure
REQ-032 SHALL take LANES, LANE_W and the FSM state encoding (IDLE, SEND) from shared package sorter_pkg, also used by the sorter.
REQ-033 SHALL place the REQ-024 comparison in one combinational sub-module order_checker (inputs: packed word; output: violation flag).

Verification
REQ-034 Reset then one word 0x0102030405060708 with out_ready=1 -> bytes 08,07,06,05,04,03,02,01, indices 0..7, out_last on 01, order_err never high.
REQ-035 Word 0x0000000000000001 (non-increasing) -> order_err stays 0; word 0x0800000000000001 -> order_err one pulse on cycle after capture, err_count 1, all 8 lanes still emitted.
REQ-036 Two words back-to-back, in_valid held high, out_ready=1 -> 16 consecutive out_valid cycles, no gap, second word lane 0 the cycle after first out_last.
REQ-037 out_ready low 3 cycles while lane 2 presented -> out_byte/out_index hold lane 2 values, in_ready stays 0.
REQ-038 rst asserted at lane 4 of a word -> next cycle out_valid=0, in_ready=1, err_count=0; new word restarts at index 0.
REQ-039 300 consecutive mis-ordered words -> err_count saturates at 255.

Source files
------------

// File: rtl/sorter_pkg.sv
// sorter_pkg: lane geometry and FSM state encoding shared by the sorter and its unpacker
package sorter_pkg;
  localparam int LANES = 8;
  localparam int LANE_W = 8;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/order_checker.sv
// order_checker: flags a packed word whose lanes are not non-increasing from lane 0 upward
module order_checker #(
  parameter int LANES = sorter_pkg::LANES,
  parameter int LANE_W = sorter_pkg::LANE_W
) (
  input  logic [LANES*LANE_W-1:0] data,
  output logic                    bad
);
  // any lane smaller than its successor is an ordering violation; equal lanes are fine
  always_comb begin
    bad = 1'b0;
    for (int k = 0; k < LANES - 1; k++)
      bad = bad | (data[k*LANE_W +: LANE_W] < data[(k+1)*LANE_W +: LANE_W]);
  end
endmodule

// File: rtl/sorted_unpacker.sv
// sorted_unpacker: holds one sorted packed word and streams its lanes out one per handshake
module sorted_unpacker #(
  parameter int LANES = sorter_pkg::LANES,
  parameter int LANE_W = sorter_pkg::LANE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES*LANE_W-1:0]    in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [LANE_W-1:0]          out_byte,
  output logic [$clog2(LANES)-1:0]   out_index,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       order_err,
  output logic [7:0]                 err_count
);
  import sorter_pkg::*;
  localparam int IW = $clog2(LANES);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [LANES*LANE_W-1:0] hold;
  logic bad, take, fire;
  order_checker #(.LANES(LANES), .LANE_W(LANE_W)) u_chk (.data(in_data), .bad(bad));
  // presentation of the held lane, handshakes, and next state; a new word may enter as the last lane leaves
  always_comb begin
    out_valid = state == SEND;
    out_last = out_valid && idx == IW'(LANES - 1);
    out_byte = out_valid ? hold[int'(idx)*LANE_W +: LANE_W] : '0;
    out_index = out_valid ? idx : '0;
    fire = out_valid && out_ready;
    in_ready = !out_valid || (out_last && out_ready);
    take = in_valid && in_ready;
    state_n = take ? SEND : (fire && out_last) ? IDLE : state;
    idx_n = (take || (fire && out_last)) ? '0 : fire ? idx + 1'b1 : idx;
  end
  // state, lane index, holding register and the order-error pulse/counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      hold <= '0;
      order_err <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      if (take) hold <= in_data;
      order_err <= take && bad;
      if (take && bad && err_count != 8'hff) err_count <= err_count + 1'b1;
    end
  end
endmodule
